// File: rtl/mbc6_flash_mapper.sv
// Dual-window GB cartridge mapper with on-cart flash emulation: bank registers,
// a JEDEC-style command FSM, busy/toggle status reads and a flash-image write port.
module mbc6_flash_mapper #(
  parameter int ROM_BANK_W   = 7,
  parameter int FLASH_BANK_W = 7,
  parameter int RAM_BANK_W   = 3,
  parameter int SECTOR_LOG2  = 13
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        ce_cpu,
  input  logic        savestate_load,
  input  logic [63:0] savestate_data,
  output logic [63:0] savestate_back,
  input  logic        has_ram,
  input  logic [1:0]  ram_mask,
  input  logic [5:0]  rom_mask,
  input  logic [15:0] cart_addr,
  input  logic        cart_rd,
  input  logic        cart_wr,
  input  logic [7:0]  cart_di,
  input  logic [7:0]  rom_di,
  output logic [7:0]  rom_do,
  input  logic [7:0]  cram_di,
  output logic [7:0]  cram_do,
  output logic [16:0] cram_addr,
  output logic [9:0]  mbc_bank,
  output logic        ram_enabled,
  output logic        has_battery,
  output logic        fw_req,
  output logic [19:0] fw_addr,
  output logic [7:0]  fw_data,
  input  logic        fw_ack
);
  localparam int BANK_W = (ROM_BANK_W > FLASH_BANK_W) ? ROM_BANK_W : FLASH_BANK_W;
  localparam logic [19:0] SECT_MASK = 20'((64'd1 << SECTOR_LOG2) - 64'd1);
  localparam logic [19:0] CHIP_MASK = 20'((64'd1 << (13 + FLASH_BANK_W)) - 64'd1);

  typedef enum logic [3:0] {IDLE, U1, U2, PROG, E0, E1, E2, ERASE, BUSY_P, ID} state_t;
  state_t state, state_next;

  logic [BANK_W-1:0]     bank_a, bank_b, win_bank;
  logic [RAM_BANK_W-1:0] ram_a, ram_b, ram_sel;
  logic [ROM_BANK_W-1:0] rom_bank;
  logic                  ram_en, flash_en, flash_we, sel_a, sel_b;
  logic                  req, chip, tgl, rd_prev;
  logic [19:0]           faddr, win_addr, emask, step_addr;
  logic [7:0]            fdata;
  logic                  wr, win_sel, flash_win, fwr, busy, last, ack_done;
  logic [11:0]           off;
  logic                  unused_bits;

  assign wr        = cart_wr & ce_cpu;
  assign win_sel   = cart_addr[13] ? sel_b : sel_a;
  assign win_bank  = cart_addr[13] ? bank_b : bank_a;
  assign flash_win = (cart_addr[15:14] == 2'b01) & win_sel & flash_en;
  assign fwr       = wr & flash_win & flash_we;
  assign off       = cart_addr[11:0];
  assign win_addr  = 20'({win_bank[FLASH_BANK_W-1:0], cart_addr[12:0]});
  assign busy      = (state == BUSY_P) || (state == ERASE);
  assign ack_done  = req & fw_ack;

  // Erase walks only the bits under the mask, so a sector erase stays inside its sector.
  assign emask     = chip ? CHIP_MASK : SECT_MASK;
  assign last      = (faddr & emask) == emask;
  assign step_addr = (faddr & ~emask) | ((faddr + 20'd1) & emask);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (fwr && off == 12'h555 && cart_di == 8'hAA) state_next = U1;
      U1:     if (fwr) state_next = (off == 12'h2AA && cart_di == 8'h55) ? U2 : IDLE;
      U2: begin
        if (fwr) begin
          state_next = IDLE;
          if (off == 12'h555 && cart_di == 8'hA0) state_next = PROG;
          if (off == 12'h555 && cart_di == 8'h80) state_next = E0;
          if (off == 12'h555 && cart_di == 8'h90) state_next = ID;
        end
      end
      PROG:   if (fwr) state_next = BUSY_P;
      E0:     if (fwr) state_next = (off == 12'h555 && cart_di == 8'hAA) ? E1 : IDLE;
      E1:     if (fwr) state_next = (off == 12'h2AA && cart_di == 8'h55) ? E2 : IDLE;
      E2:     if (fwr) state_next = (cart_di == 8'h30 || cart_di == 8'h10) ? ERASE : IDLE;
      ERASE:  if (ack_done && last) state_next = IDLE;
      BUSY_P: if (ack_done) state_next = IDLE;
      ID:     if (fwr && cart_di == 8'hF0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                       state <= IDLE;
    else if (savestate_load || !enable) state <= IDLE;
    else                                state <= state_next;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      bank_a <= '0; bank_b <= '0; ram_a <= '0; ram_b <= '0;
      ram_en <= 1'b0; flash_en <= 1'b0; flash_we <= 1'b0; sel_a <= 1'b0; sel_b <= 1'b0;
      req <= 1'b0; chip <= 1'b0; tgl <= 1'b0; rd_prev <= 1'b0;
      faddr <= '0; fdata <= '0;
    end else if (savestate_load) begin
      bank_a   <= BANK_W'(savestate_data[6:0]);
      bank_b   <= BANK_W'(savestate_data[13:7]);
      ram_a    <= RAM_BANK_W'(savestate_data[16:14]);
      ram_b    <= RAM_BANK_W'(savestate_data[19:17]);
      ram_en   <= savestate_data[20];
      flash_en <= savestate_data[21];
      flash_we <= savestate_data[22];
      sel_a    <= savestate_data[23];
      sel_b    <= savestate_data[24];
      req      <= 1'b0;
      tgl      <= 1'b0;
    end else if (!enable) begin
      bank_a <= '0; bank_b <= '0; ram_a <= '0; ram_b <= '0;
      ram_en <= 1'b0; flash_en <= 1'b0; flash_we <= 1'b0; sel_a <= 1'b0; sel_b <= 1'b0;
      req <= 1'b0; chip <= 1'b0; tgl <= 1'b0; rd_prev <= 1'b0;
      faddr <= '0; fdata <= '0;
    end else begin
      if (wr && cart_addr[15:13] == 3'b000) begin
        case (cart_addr[12:10])
          3'd0: ram_en   <= (cart_di[3:0] == 4'hA);
          3'd1: ram_a    <= RAM_BANK_W'(cart_di);
          3'd2: ram_b    <= RAM_BANK_W'(cart_di);
          3'd3: flash_en <= cart_di[0];
          3'd4: flash_we <= cart_di[0];
          default: ;
        endcase
      end
      if (wr && cart_addr[15:13] == 3'b001) begin
        case (cart_addr[12:11])
          2'd0: bank_a <= BANK_W'(cart_di);
          2'd1: sel_a  <= (cart_di[3:0] == 4'h8);
          2'd2: bank_b <= BANK_W'(cart_di);
          default: sel_b <= (cart_di[3:0] == 4'h8);
        endcase
      end
      if (ce_cpu) rd_prev <= cart_rd;
      if (!busy) tgl <= 1'b0;
      else if (ce_cpu && rd_prev && !cart_rd) tgl <= ~tgl;

      if (state == PROG && fwr) begin
        faddr <= win_addr;
        fdata <= cart_di;
      end
      if (state == E2 && fwr && (cart_di == 8'h30 || cart_di == 8'h10)) begin
        chip  <= (cart_di == 8'h10);
        faddr <= (cart_di == 8'h10) ? 20'd0 : (win_addr & ~SECT_MASK);
        fdata <= 8'hFF;
      end
      // One request at a time: raise, hold until ack, drop for a cycle, advance.
      if (busy) begin
        if (ack_done) begin
          req <= 1'b0;
          if (state == ERASE && !last) faddr <= step_addr;
        end else if (!req) begin
          req <= 1'b1;
        end
      end
    end
  end

  assign rom_bank = win_bank[ROM_BANK_W-1:0] & ROM_BANK_W'({rom_mask, 1'b1});
  assign ram_sel  = cart_addr[12] ? ram_b : ram_a;

  always_comb begin
    mbc_bank = '0;
    if (!cart_addr[15]) begin
      if (!cart_addr[14])           mbc_bank = 10'(cart_addr[13]);
      else if (win_sel && flash_en) mbc_bank = {1'b1, 9'(win_bank[FLASH_BANK_W-1:0])};
      else                          mbc_bank = 10'(rom_bank);
    end
  end

  always_comb begin
    rom_do = rom_di;
    if (flash_win) begin
      if (busy)                              rom_do = {(state == BUSY_P) ? ~fdata[7] : 1'b0, tgl, 6'b0};
      else if (state == ID && off == 12'd0)  rom_do = 8'hC2;
      else if (state == ID && off == 12'd1)  rom_do = 8'h81;
    end
  end

  assign cram_addr      = 17'({ram_sel & RAM_BANK_W'({ram_mask, 1'b1}), cart_addr[11:0]});
  assign ram_enabled    = ram_en & has_ram;
  assign cram_do        = ram_enabled ? cram_di : 8'hFF;
  assign has_battery    = has_ram;
  assign fw_req         = req & enable;
  assign fw_addr        = faddr;
  assign fw_data        = fdata;
  assign savestate_back = {39'd0, sel_b, sel_a, flash_we, flash_en, ram_en,
                           3'(ram_b), 3'(ram_a), 7'(bank_b), 7'(bank_a)};
  assign unused_bits    = ^savestate_data[63:25];
endmodule
